// File: rtl/step_clk_gen_pkg.sv
// rtl/step_clk_gen_pkg.sv - shared FSM encoding, default parameters and helpers for step_clk_gen
// Purpose: common definitions imported by step_clk_gen and btn_debounce.
// Ports: none (package).
package step_clk_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_PULSE_HIGH      = 4;
  localparam int DEF_RUN_DIV         = 50000000;
  localparam int DEF_CNT_W           = 16;

  // Bits needed for a counter that runs 0..n-1; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/step_clk_gen_btn_debounce.sv
// rtl/step_clk_gen_btn_debounce.sv - button synchroniser and debounce filter
// Purpose: brings the raw push-button into the clock domain and accepts a
//   new level only after it has been stable for DEBOUNCE_CYCLES clocks.
// Ports:
//   clock      in   system clock
//   Reset      in   asynchronous active-low reset
//   btn        in   raw, bouncy, asynchronous button
//   btn_level  out  debounced button level (registered)
module btn_debounce
  import step_clk_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic Reset,
  input  logic btn,
  output logic btn_level
);

  localparam int              CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          btn_s1;
  logic          sync_btn;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      btn_s1   <= 1'b0;
      sync_btn <= 1'b0;
    end else begin
      btn_s1   <= btn;
      sync_btn <= btn_s1;
    end
  end

  // Any return to the accepted level restarts the stability count, so a
  // bounce shorter than DEBOUNCE_CYCLES can never change btn_level.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      cnt       <= '0;
      btn_level <= 1'b0;
    end else if (sync_btn == btn_level) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      btn_level <= sync_btn;
      cnt       <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/step_clk_gen.sv
// rtl/step_clk_gen.sv - single-step / free-run CPU clock generator
// Purpose: produces one fixed-width cpu_clk pulse per debounced button press
//   (step mode) or one pulse every RUN_DIV clocks (run mode).
// Ports:
//   clock       in   board system clock, rising edge
//   Reset       in   asynchronous active-low reset
//   btn         in   raw push-button, asynchronous
//   run_en      in   mode switch, asynchronous (0 = step, 1 = run)
//   cpu_clk     out  generated CPU clock, registered
//   step_pulse  out  one-clock strobe in the cycle cpu_clk rises
//   step_count  out  pulses issued since reset, wraps
//   btn_level   out  debounced button level
module step_clk_gen
  import step_clk_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int PULSE_HIGH      = DEF_PULSE_HIGH,
  parameter int RUN_DIV         = DEF_RUN_DIV,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic             btn,
  input  logic             run_en,
  output logic             cpu_clk,
  output logic             step_pulse,
  output logic [CNT_W-1:0] step_count,
  output logic             btn_level
);

  localparam int            DW       = cnt_width(RUN_DIV);
  localparam int            PW       = cnt_width(PULSE_HIGH);
  localparam logic [DW-1:0] DIV_LAST = DW'(RUN_DIV - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(PULSE_HIGH - 1);

  logic          run_s1;
  logic          run_sync;
  logic          btn_level_d;
  logic [DW-1:0] div;
  logic          run_tick;
  logic          step_req;
  logic          req;

  state_t        state;
  state_t        state_nx;
  logic [PW-1:0] pcnt;
  logic [PW-1:0] pcnt_nx;
  logic          cpu_clk_nx;
  logic          fire;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clock    (clock),
    .Reset    (Reset),
    .btn      (btn),
    .btn_level(btn_level)
  );

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      run_s1      <= 1'b0;
      run_sync    <= 1'b0;
      btn_level_d <= 1'b0;
    end else begin
      run_s1      <= run_en;
      run_sync    <= run_s1;
      btn_level_d <= btn_level;
    end
  end

  // Divider is parked at zero in step mode so run mode always starts with a
  // full RUN_DIV interval before the first pulse.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      div <= '0;
    end else if (!run_sync) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  assign run_tick = run_sync & (div == DIV_LAST);
  assign step_req = ~run_sync & btn_level & ~btn_level_d;
  assign req      = run_tick | step_req;

  // Requests are only honoured in IDLE; anything arriving during HIGH or LOW
  // is simply lost, which keeps the minimum low time intact.
  always_comb begin
    state_nx   = state;
    pcnt_nx    = pcnt;
    cpu_clk_nx = cpu_clk;
    fire       = 1'b0;
    case (state)
      ST_IDLE: begin
        cpu_clk_nx = 1'b0;
        if (req) begin
          state_nx   = ST_HIGH;
          pcnt_nx    = '0;
          cpu_clk_nx = 1'b1;
          fire       = 1'b1;
        end
      end
      ST_HIGH: begin
        if (pcnt == PH_LAST) begin
          state_nx   = ST_LOW;
          pcnt_nx    = '0;
          cpu_clk_nx = 1'b0;
        end else begin
          pcnt_nx = pcnt + PW'(1);
        end
      end
      ST_LOW: begin
        cpu_clk_nx = 1'b0;
        if (pcnt == PH_LAST) begin
          state_nx = ST_IDLE;
          pcnt_nx  = '0;
        end else begin
          pcnt_nx = pcnt + PW'(1);
        end
      end
      default: begin
        state_nx   = ST_IDLE;
        pcnt_nx    = '0;
        cpu_clk_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state      <= ST_IDLE;
      pcnt       <= '0;
      cpu_clk    <= 1'b0;
      step_pulse <= 1'b0;
      step_count <= '0;
    end else begin
      state      <= state_nx;
      pcnt       <= pcnt_nx;
      cpu_clk    <= cpu_clk_nx;
      step_pulse <= fire;
      if (fire) begin
        step_count <= step_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_step_clk_gen.sv
// tb/tb_step_clk_gen.sv - directed self-checking bench for step_clk_gen
module tb_step_clk_gen;

  logic       clk;
  logic       rst_n;
  logic       btn;
  logic       run_en;
  logic       cpu_clk;
  logic       step_pulse;
  logic [3:0] step_count;
  logic       btn_level;

  int checks;
  int errors;
  int rise_cnt;
  int sp_cnt;

  step_clk_gen #(
    .DEBOUNCE_CYCLES(4),
    .PULSE_HIGH     (2),
    .RUN_DIV        (10),
    .CNT_W          (4)
  ) dut (
    .clock     (clk),
    .Reset     (rst_n),
    .btn       (btn),
    .run_en    (run_en),
    .cpu_clk   (cpu_clk),
    .step_pulse(step_pulse),
    .step_count(step_count),
    .btn_level (btn_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial rise_cnt = 0;
  always @(posedge cpu_clk) rise_cnt = rise_cnt + 1;

  initial sp_cnt = 0;
  always @(negedge clk) if (step_pulse === 1'b1) sp_cnt = sp_cnt + 1;

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    btn    = 1'b0;
    run_en = 1'b0;
    wait_neg(3);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({cpu_clk, step_pulse, step_count, btn_level} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, want 0000000", {cpu_clk, step_pulse, step_count, btn_level});
    end
  endtask

  task automatic test_clean_press();
    int r0, s0;
    apply_reset();
    r0 = rise_cnt;
    s0 = sp_cnt;
    btn = 1'b1;
    wait_neg(6);
    checks++;
    if (cpu_clk !== 1'b0 || btn_level !== 1'b1) begin
      errors++;
      $display("FAIL press_edge6: cpu_clk=%b btn_level=%b, want 0 1", cpu_clk, btn_level);
    end
    wait_neg(1);
    checks++;
    if (cpu_clk !== 1'b1 || step_pulse !== 1'b1 || step_count !== 4'd1) begin
      errors++;
      $display("FAIL press_edge7: cpu_clk=%b step_pulse=%b step_count=%0d, want 1 1 1", cpu_clk, step_pulse, step_count);
    end
    wait_neg(1);
    checks++;
    if (cpu_clk !== 1'b1 || step_pulse !== 1'b0) begin
      errors++;
      $display("FAIL press_edge8: cpu_clk=%b step_pulse=%b, want 1 0", cpu_clk, step_pulse);
    end
    wait_neg(1);
    checks++;
    if (cpu_clk !== 1'b0) begin
      errors++;
      $display("FAIL press_edge9: cpu_clk=%b, want 0", cpu_clk);
    end
    wait_neg(20);
    checks++;
    if (rise_cnt - r0 !== 1 || sp_cnt - s0 !== 1 || step_count !== 4'd1) begin
      errors++;
      $display("FAIL press_single: rises=%0d strobes=%0d count=%0d, want 1 1 1", rise_cnt - r0, sp_cnt - s0, step_count);
    end
  endtask

  task automatic test_bounce();
    int r0;
    apply_reset();
    r0 = rise_cnt;
    btn = 1'b1; wait_neg(1);
    btn = 1'b0; wait_neg(1);
    btn = 1'b1; wait_neg(1);
    btn = 1'b0; wait_neg(1);
    btn = 1'b1;
    wait_neg(6);
    checks++;
    if (cpu_clk !== 1'b0 || rise_cnt - r0 !== 0) begin
      errors++;
      $display("FAIL bounce_edge6: cpu_clk=%b rises=%0d, want 0 0", cpu_clk, rise_cnt - r0);
    end
    wait_neg(1);
    checks++;
    if (cpu_clk !== 1'b1 || step_count !== 4'd1) begin
      errors++;
      $display("FAIL bounce_edge7: cpu_clk=%b step_count=%0d, want 1 1", cpu_clk, step_count);
    end
    wait_neg(10);
    btn = 1'b0; wait_neg(1);
    btn = 1'b1; wait_neg(1);
    btn = 1'b0; wait_neg(1);
    btn = 1'b1; wait_neg(1);
    btn = 1'b0;
    wait_neg(20);
    checks++;
    if (btn_level !== 1'b0 || rise_cnt - r0 !== 1 || step_count !== 4'd1) begin
      errors++;
      $display("FAIL bounce_release: btn_level=%b rises=%0d count=%0d, want 0 1 1", btn_level, rise_cnt - r0, step_count);
    end
  endtask

  task automatic test_back_to_back();
    int r0;
    apply_reset();
    r0 = rise_cnt;
    btn = 1'b1;
    wait_neg(7);
    checks++;
    if (cpu_clk !== 1'b1 || step_count !== 4'd1) begin
      errors++;
      $display("FAIL b2b_first: cpu_clk=%b step_count=%0d, want 1 1", cpu_clk, step_count);
    end
    wait_neg(1);
    btn = 1'b0;
    wait_neg(1);
    btn = 1'b1;
    wait_neg(20);
    checks++;
    if (rise_cnt - r0 !== 1 || step_count !== 4'd1) begin
      errors++;
      $display("FAIL b2b_dropped: rises=%0d count=%0d, want 1 1", rise_cnt - r0, step_count);
    end
    btn = 1'b0;
    wait_neg(20);
    btn = 1'b1;
    wait_neg(6);
    checks++;
    if (cpu_clk !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_edge6: cpu_clk=%b, want 0", cpu_clk);
    end
    wait_neg(1);
    checks++;
    if (cpu_clk !== 1'b1 || step_pulse !== 1'b1 || step_count !== 4'd2) begin
      errors++;
      $display("FAIL b2b_second: cpu_clk=%b step_pulse=%b count=%0d, want 1 1 2", cpu_clk, step_pulse, step_count);
    end
    wait_neg(10);
    checks++;
    if (rise_cnt - r0 !== 2) begin
      errors++;
      $display("FAIL b2b_total: rises=%0d, want 2", rise_cnt - r0);
    end
  endtask

  task automatic test_run_mode();
    int r0;
    logic [3:0] exp_cnt;
    apply_reset();
    r0 = rise_cnt;
    run_en = 1'b1;
    wait_neg(11);
    checks++;
    if (cpu_clk !== 1'b0 || rise_cnt - r0 !== 0) begin
      errors++;
      $display("FAIL run_edge11: cpu_clk=%b rises=%0d, want 0 0", cpu_clk, rise_cnt - r0);
    end
    wait_neg(1);
    checks++;
    if (cpu_clk !== 1'b1 || step_pulse !== 1'b1 || step_count !== 4'd1) begin
      errors++;
      $display("FAIL run_first: cpu_clk=%b step_pulse=%b count=%0d, want 1 1 1", cpu_clk, step_pulse, step_count);
    end
    for (int k = 2; k <= 16; k++) begin
      btn = k[0];
      exp_cnt = k[3:0];
      wait_neg(9);
      checks++;
      if (step_pulse !== 1'b0 || cpu_clk !== 1'b0) begin
        errors++;
        $display("FAIL run_gap_%0d: step_pulse=%b cpu_clk=%b, want 0 0", k, step_pulse, cpu_clk);
      end
      wait_neg(1);
      checks++;
      if (step_pulse !== 1'b1 || step_count !== exp_cnt) begin
        errors++;
        $display("FAIL run_pulse_%0d: step_pulse=%b count=%0d, want 1 %0d", k, step_pulse, step_count, exp_cnt);
      end
    end
    checks++;
    if (rise_cnt - r0 !== 16 || step_count !== 4'd0) begin
      errors++;
      $display("FAIL run_wrap: rises=%0d count=%0d, want 16 0", rise_cnt - r0, step_count);
    end
    run_en = 1'b0;
    btn = 1'b0;
  endtask

  task automatic test_reset_mid_pulse();
    apply_reset();
    btn = 1'b1;
    wait_neg(7);
    checks++;
    if (cpu_clk !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: cpu_clk=%b, want 1", cpu_clk);
    end
    #2;
    rst_n = 1'b0;
    btn   = 1'b0;
    #1;
    checks++;
    if (cpu_clk !== 1'b0 || step_count !== 4'd0 || step_pulse !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: cpu_clk=%b step_count=%0d step_pulse=%b, want 0 0 0", cpu_clk, step_count, step_pulse);
    end
    wait_neg(3);
    rst_n = 1'b1;
    btn = 1'b1;
    wait_neg(6);
    checks++;
    if (cpu_clk !== 1'b0) begin
      errors++;
      $display("FAIL midrst_again_edge6: cpu_clk=%b, want 0", cpu_clk);
    end
    wait_neg(1);
    checks++;
    if (cpu_clk !== 1'b1 || step_count !== 4'd1) begin
      errors++;
      $display("FAIL midrst_again_edge7: cpu_clk=%b count=%0d, want 1 1", cpu_clk, step_count);
    end
  endtask

  task automatic test_mode_switch();
    int r0;
    apply_reset();
    r0 = rise_cnt;
    run_en = 1'b1;
    wait_neg(12);
    checks++;
    if (cpu_clk !== 1'b1) begin
      errors++;
      $display("FAIL switch_high: cpu_clk=%b, want 1", cpu_clk);
    end
    run_en = 1'b0;
    wait_neg(1);
    checks++;
    if (cpu_clk !== 1'b1) begin
      errors++;
      $display("FAIL switch_hold: cpu_clk=%b, want 1", cpu_clk);
    end
    wait_neg(1);
    checks++;
    if (cpu_clk !== 1'b0) begin
      errors++;
      $display("FAIL switch_fall: cpu_clk=%b, want 0", cpu_clk);
    end
    wait_neg(30);
    checks++;
    if (rise_cnt - r0 !== 1 || step_count !== 4'd1 || cpu_clk !== 1'b0) begin
      errors++;
      $display("FAIL switch_quiet: rises=%0d count=%0d cpu_clk=%b, want 1 1 0", rise_cnt - r0, step_count, cpu_clk);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    btn    = 1'b0;
    run_en = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_back_to_back();
    test_run_mode();
    test_reset_mid_pulse();
    test_mode_switch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
